gfe_pivot_cell: RTL

Pivot cell at the head of each row of the GF(2^m) Gaussian-elimination systolic array. It sits directly upstream of the row's processor_B cells and generates the op/factor stream they consume. It watches its own column, holds the pivot, and computes the pivot inverse iteratively. It then issues pass (00), normalize (11, fac = inverse) or eliminate (10, fac = element) per row element.

---
 rtl/gfe_pkg.sv | 18 +
 rtl/gfe_inv_seq.sv | 92 +++++++++
 rtl/gfe_pivot_cell.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gfe_pkg.sv
// Shared definitions for the GF(2^m) Gaussian-elimination array.
// Contains the op encodings, the default reduction polynomial and the pivot-cell states.
package gfe_pkg;

   localparam logic [12:0] POLY_DEFAULT = 13'h001B;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_SWAP = 2'b01;
   localparam logic [1:0] OP_ELIM = 2'b10;
   localparam logic [1:0] OP_NORM = 2'b11;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_INVERT = 2'b01,
      ST_ELIM   = 2'b10
   } state_e;

endpackage

// File: rtl/gfe_inv_seq.sv
// Iterative GF(2^m) inverter: computes a^(2^m-2) using one square-multiply step per cycle.
// done_o is raised in the last busy cycle, and inv_o carries the final squaring in that cycle.
module gfe_inv_seq
   import gfe_pkg::*;
#(
   parameter int unsigned      WIDTH = 13,
   parameter logic [WIDTH-1:0] POLY  = POLY_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] inv_o
);

   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   ITER = CW'(WIDTH - 2);

   function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] t;
      p = {WIDTH{1'b0}};
      t = x;
      for (int i = 0; i < WIDTH; i++) begin
         if (y[i]) begin
            p = p ^ t;
         end
         if (t[WIDTH-1]) begin
            t = {t[WIDTH-2:0], 1'b0} ^ POLY;
         end else begin
            t = {t[WIDTH-2:0], 1'b0};
         end
      end
      return p;
   endfunction

   function automatic logic [WIDTH-1:0] gf_sq(input logic [WIDTH-1:0] x);
      return gf_mul(x, x);
   endfunction

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] sq_s;
   logic [WIDTH-1:0] step_s;

   assign sq_s   = gf_sq(acc_q);
   assign step_s = gf_mul(sq_s, a_q);
   assign done_o = busy_q && (cnt_q == {CW{1'b0}});
   assign busy_o = busy_q;
   assign inv_o  = sq_s;

   // Iteration control: load on start, square-multiply while counting down, release on done.
   always_comb begin
      acc_d  = acc_q;
      a_d    = a_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         acc_d  = a_i;
         a_d    = a_i;
         cnt_d  = ITER;
         busy_d = 1'b1;
      end else if (done_o) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         acc_d = step_s;
         cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         busy_d = 1'b0;
      end
   end

   // Inverter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= {WIDTH{1'b0}};
         a_q    <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         a_q    <= a_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/gfe_pivot_cell.sv
// Row-head pivot cell: finds the pivot in its column, inverts it and issues the
// pass / normalize / eliminate op stream for the downstream processor_B cells.
module gfe_pivot_cell
   import gfe_pkg::*;
#(
   parameter int unsigned      WIDTH = 13,
   parameter logic [WIDTH-1:0] POLY  = POLY_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             start_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   output logic [1:0]       op_out,
   output logic [WIDTH-1:0] fac_out,
   output logic             start_out,
   output logic [WIDTH-1:0] data_out
);

   state_e           state_q, state_d;
   logic             accept_s, eff_search_s, inv_start_s;
   logic             inv_busy_s, inv_done_s;
   logic [WIDTH-1:0] inv_s;

   logic             pend_vld_q, pend_vld_d;
   logic [1:0]       pend_op_q, pend_op_d;
   logic [WIDTH-1:0] pend_fac_q, pend_fac_d;
   logic             pend_st_q, pend_st_d;
   logic             piv_st_q, piv_st_d;

   logic             out_valid_q, out_valid_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] fac_q, fac_d;
   logic             st_q, st_d;
   logic [WIDTH-1:0] data_q, data_d;

   gfe_inv_seq #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_inv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (inv_start_s),
      .a_i     (data_in),
      .busy_o  (inv_busy_s),
      .done_o  (inv_done_s),
      .inv_o   (inv_s)
   );

   assign in_ready  = ~inv_busy_s;
   assign out_valid = out_valid_q;
   assign op_out    = op_q;
   assign fac_out   = fac_q;
   assign start_out = st_q;
   assign data_out  = data_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; start_in on an accepted element always re-enters the search.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH, ST_ELIM: begin
            if (inv_start_s) begin
               state_d = ST_INVERT;
            end else if (accept_s && start_in) begin
               state_d = ST_SEARCH;
            end else begin
               state_d = state_q;
            end
         end
         ST_INVERT: begin
            if (inv_done_s) begin
               state_d = ST_ELIM;
            end else begin
               state_d = ST_INVERT;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // Per-element decode: a nonzero element seen while searching becomes the pivot.
   always_comb begin
      accept_s     = in_valid && !inv_busy_s;
      eff_search_s = start_in || (state_q == ST_SEARCH);
      inv_start_s  = accept_s && eff_search_s && (data_in != {WIDTH{1'b0}});
      pend_vld_d   = accept_s && !inv_start_s;
      pend_st_d    = start_in;
      if (eff_search_s) begin
         pend_op_d  = OP_PASS;
         pend_fac_d = {WIDTH{1'b0}};
      end else begin
         pend_op_d  = OP_ELIM;
         pend_fac_d = data_in;
      end
      if (inv_start_s) begin
         piv_st_d = start_in;
      end else begin
         piv_st_d = piv_st_q;
      end
   end

   // Output selection; the pivot column is always cleared, so data_out stays zero.
   always_comb begin
      out_valid_d = 1'b0;
      op_d        = op_q;
      fac_d       = fac_q;
      st_d        = st_q;
      data_d      = {WIDTH{1'b0}};
      if (inv_done_s) begin
         out_valid_d = 1'b1;
         op_d        = OP_NORM;
         fac_d       = inv_s;
         st_d        = piv_st_q;
      end else if (pend_vld_q) begin
         out_valid_d = 1'b1;
         op_d        = pend_op_q;
         fac_d       = pend_fac_q;
         st_d        = pend_st_q;
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // Pending element stage and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_vld_q  <= 1'b0;
         pend_op_q   <= OP_PASS;
         pend_fac_q  <= {WIDTH{1'b0}};
         pend_st_q   <= 1'b0;
         piv_st_q    <= 1'b0;
         out_valid_q <= 1'b0;
         op_q        <= OP_PASS;
         fac_q       <= {WIDTH{1'b0}};
         st_q        <= 1'b0;
         data_q      <= {WIDTH{1'b0}};
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_op_q   <= pend_op_d;
         pend_fac_q  <= pend_fac_d;
         pend_st_q   <= pend_st_d;
         piv_st_q    <= piv_st_d;
         out_valid_q <= out_valid_d;
         op_q        <= op_d;
         fac_q       <= fac_d;
         st_q        <= st_d;
         data_q      <= data_d;
      end
   end

endmodule
